// File: rtl/conv_row_feeder.sv
// Tile-by-tile pixel fetcher: reads Pix core pixels plus kx/2 halo pixels on each side for the conv loop.
// Optional feature macro CONV_FEEDER_REPLICATE_EN: replicate edge pixels instead of zero padding.
module conv_row_feeder #(
    parameter int kx     = 3,
    parameter int Pix    = 3,
    parameter int RES    = 8,
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 4,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              mem_rd_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [RES-1:0]                    mem_rd_data,
    output logic [Pix+(kx/2)-1:0][RES-1:0]    pixel_row,
    output logic [(kx/2)-1:0][RES-1:0]        west_paddings,
    output logic                              pixel_ready,
    input  logic                              kernel_loop_done,
    output logic                              busy,
    output logic                              frame_done
);

    localparam int H  = kx / 2;
    localparam int N  = Pix + 2 * H;
    localparam int T  = IMG_W / Pix;
    localparam int TW = (T > 1) ? $clog2(T) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(IMG_W + N) + 2;

    localparam logic signed [CW-1:0] COL0    = CW'(-H);
    localparam logic signed [CW-1:0] PIX_S   = CW'(Pix);
    localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

    state_t                   state_q, state_d;
    logic [TW-1:0]            t_q;
    logic [RW-1:0]            r_q;
    logic [KW-1:0]            k_q;
    logic signed [CW-1:0]     tile_col_q;
    logic [ADDR_W-1:0]        row_base_q;
    logic [RES-1:0]           slot_q [N];
    logic                     pend_valid_q;
    logic                     pend_zero_q;
    logic [KW-1:0]            pend_idx_q;

    logic signed [CW-1:0]     col;
    logic [CW-1:0]            rd_col;
    logic                     slot_read;
    logic                     ack;
    logic                     last_slot;
    logic                     last_tile;
    logic                     last_row;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Column of the current slot, read decision, handshake outputs and next state
    always_comb begin
        state_d     = state_q;
        col         = tile_col_q + $signed(CW'(k_q));
        last_slot   = (k_q == KW'(N - 1));
        last_tile   = (t_q == TW'(T - 1));
        last_row    = (r_q == RW'(IMG_H - 1));
        ack         = (state_q == PRESENT) && kernel_loop_done;
`ifdef CONV_FEEDER_REPLICATE_EN
        slot_read   = 1'b1;
        if (col[CW-1])          rd_col = '0;
        else if (col >= IMG_W_S) rd_col = IMG_W_S - 1'b1;
        else                     rd_col = col;
`else
        slot_read   = !col[CW-1] && (col < IMG_W_S);
        rd_col      = col;
`endif
        mem_rd_en   = (state_q == FETCH) && slot_read;
        mem_addr    = mem_rd_en ? row_base_q + ADDR_W'(rd_col) : '0;
        pixel_ready = (state_q == PRESENT);
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (last_slot) state_d = DRAIN;
            DRAIN:   state_d = PRESENT;
            PRESENT: if (ack) state_d = (last_tile && last_row) ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Counters, one-cycle read pipeline into the slot registers, frame completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q          <= '0;
            r_q          <= '0;
            k_q          <= '0;
            tile_col_q   <= '0;
            row_base_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_zero_q  <= 1'b0;
            pend_idx_q   <= '0;
            frame_done   <= 1'b0;
            for (int i = 0; i < N; i++) slot_q[i] <= '0;
        end else begin
            frame_done   <= ack && last_tile && last_row;
            pend_valid_q <= (state_q == FETCH);
            pend_zero_q  <= !mem_rd_en;
            pend_idx_q   <= k_q;
            if (pend_valid_q) slot_q[pend_idx_q] <= pend_zero_q ? '0 : mem_rd_data;

            if (state_q == IDLE && start) begin
                t_q        <= '0;
                r_q        <= '0;
                k_q        <= '0;
                tile_col_q <= COL0;
                row_base_q <= '0;
            end
            if (state_q == FETCH) k_q <= last_slot ? '0 : k_q + 1'b1;
            if (ack) begin
                if (!last_tile) begin
                    t_q        <= t_q + 1'b1;
                    tile_col_q <= tile_col_q + PIX_S;
                end else begin
                    t_q        <= '0;
                    tile_col_q <= COL0;
                    if (last_row) begin
                        r_q        <= '0;
                        row_base_q <= '0;
                    end else begin
                        r_q        <= r_q + 1'b1;
                        row_base_q <= row_base_q + ADDR_W'(IMG_W);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < Pix + H; i++) pixel_row[i] = slot_q[H + i];
        for (int j = 0; j < H; j++)       west_paddings[j] = slot_q[j];
    end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Scoreboard bench for conv_row_feeder on a 6x2 image with img[r][c] = 10r + c + 1.
module tb_conv_row_feeder;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 mem_rd_en;
    logic [3:0]           mem_addr;
    logic [7:0]           mem_rd_data;
    logic [3:0][7:0]      pixel_row;
    logic [0:0][7:0]      west_paddings;
    logic                 pixel_ready;
    logic                 kernel_loop_done;
    logic                 busy;
    logic                 frame_done;

    typedef struct {
        logic [7:0]      west;
        logic [3:0][7:0] row;
    } tile_t;

    tile_t exp_tiles[$];
    int    exp_addrs[$];
    tile_t cur_tile;
    logic  cur_valid = 1'b0;
    logic  prev_ready = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    fd_count = 0;
    int    cyc;

    conv_row_feeder #(
        .kx(3), .Pix(3), .RES(8), .IMG_W(6), .IMG_H(2), .ADDR_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .pixel_row(pixel_row),
        .west_paddings(west_paddings),
        .pixel_ready(pixel_ready),
        .kernel_loop_done(kernel_loop_done),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pixel memory: one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 8'(10 * (int'(mem_addr) / 6) + (int'(mem_addr) % 6) + 1);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushTile(input int w, input int p0, input int p1, input int p2, input int p3,
                            input int a0, input int a1, input int a2, input int a3, input int a4);
        tile_t tt;
        tt.west   = 8'(w);
        tt.row[0] = 8'(p0);
        tt.row[1] = 8'(p1);
        tt.row[2] = 8'(p2);
        tt.row[3] = 8'(p3);
        exp_tiles.push_back(tt);
        if (a0 >= 0) exp_addrs.push_back(a0);
        if (a1 >= 0) exp_addrs.push_back(a1);
        if (a2 >= 0) exp_addrs.push_back(a2);
        if (a3 >= 0) exp_addrs.push_back(a3);
        if (a4 >= 0) exp_addrs.push_back(a4);
    endtask

`ifdef CONV_FEEDER_REPLICATE_EN
    task automatic pushT00(); pushTile(1,  1, 2, 3, 4,     0, 0, 1, 2, 3);   endtask
    task automatic pushT01(); pushTile(3,  4, 5, 6, 6,     2, 3, 4, 5, 5);   endtask
    task automatic pushT10(); pushTile(11, 11, 12, 13, 14, 6, 6, 7, 8, 9);   endtask
    task automatic pushT11(); pushTile(13, 14, 15, 16, 16, 8, 9, 10, 11, 11); endtask
`else
    task automatic pushT00(); pushTile(0,  1, 2, 3, 4,     0, 1, 2, 3, -1);  endtask
    task automatic pushT01(); pushTile(3,  4, 5, 6, 0,     2, 3, 4, 5, -1);  endtask
    task automatic pushT10(); pushTile(0,  11, 12, 13, 14, 6, 7, 8, 9, -1);  endtask
    task automatic pushT11(); pushTile(13, 14, 15, 16, 0,  8, 9, 10, 11, -1); endtask
`endif

    // Read monitor: every strobe must match the next expected address
    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (exp_addrs.size() == 0) checkOutput("unexpected_read", 64'(mem_addr), 64'hFFFF);
            else checkOutput("read_addr", 64'(mem_addr), 64'(exp_addrs.pop_front()));
        end
    end

    // Tile monitor: pop on pixel_ready rising, hold-check while it stays high
    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (pixel_ready && !prev_ready) begin
            if (exp_tiles.size() == 0) begin
                checkOutput("unexpected_tile", 64'(pixel_row), 64'hFFFF_FFFF_FFFF);
                cur_valid = 1'b0;
            end else begin
                cur_tile  = exp_tiles.pop_front();
                cur_valid = 1'b1;
            end
        end
        if (pixel_ready && cur_valid) begin
            checkOutput("west_paddings", 64'(west_paddings[0]), 64'(cur_tile.west));
            checkOutput("pixel_row", 64'(pixel_row), 64'(cur_tile.row));
        end
        prev_ready = pixel_ready;
    end

    // Drive a one-cycle pulse sampled by the next rising edge; returns #1 after it
    task automatic applyStimulus(input logic do_start, input logic do_ack);
        start            = do_start;
        kernel_loop_done = do_ack;
        @(posedge clk);
        #1;
        start            = 1'b0;
        kernel_loop_done = 1'b0;
    endtask

    // Counts cycles from the edge just sampled until pixel_ready is seen
    task automatic waitReady(input string name, input int exp_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) checkOutput({name, "_ready_low"}, 64'(pixel_ready), 64'd0);
        end while (!pixel_ready && n < 40);
        checkOutput({name, "_latency"}, 64'(n), 64'(exp_cycles));
    endtask

    task automatic checkZeroOutputs(input string name);
        checkOutput({name, "_ready"}, 64'(pixel_ready), 64'd0);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({name, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        checkOutput({name, "_addr"}, 64'(mem_addr), 64'd0);
        checkOutput({name, "_row"}, 64'(pixel_row), 64'd0);
        checkOutput({name, "_west"}, 64'(west_paddings), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        kernel_loop_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkZeroOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame A: normal acks, an ignored start, then immediate acks via a held done
        $display("[TB] frame A");
        pushT00();
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        waitReady("t00", 7);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_in_present", 64'(busy), 64'd1);
        checkOutput("ready_after_ignored_start", 64'(pixel_ready), 64'd1);
        pushT01();
        applyStimulus(1'b0, 1'b1);
        waitReady("t01", 7);
        pushT10();
        applyStimulus(1'b0, 1'b1);
        waitReady("t10", 7);
        pushT11();
        @(posedge clk);
        #1;
        kernel_loop_done = 1'b1;
        @(posedge clk);
        #1;
        waitReady("t11", 7);
        @(negedge clk);
        checkOutput("fdA_pulse", 64'(frame_done), 64'd1);
        checkOutput("fdA_busy", 64'(busy), 64'd0);
        kernel_loop_done = 1'b0;
        @(negedge clk);
        checkOutput("fdA_single", 64'(frame_done), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("fdA_count", 64'(fd_count), 64'd1);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        // Frame B: reset in the middle of tile 1 fetch, then restart cleanly
        $display("[TB] frame B with mid-fetch reset");
        @(posedge clk);
        #1;
        pushT00();
        applyStimulus(1'b1, 1'b0);
        waitReady("b_t00", 7);
        pushT01();
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_addrs.delete();
        exp_tiles.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checkZeroOutputs("midreset");
        @(negedge clk);
        checkOutput("midreset_discard_row", 64'(pixel_row), 64'd0);
        checkOutput("midreset_discard_west", 64'(west_paddings), 64'd0);

        @(posedge clk);
        #1;
        pushT00();
        applyStimulus(1'b1, 1'b0);
        waitReady("c_t00", 7);
        pushT01();
        applyStimulus(1'b0, 1'b1);
        waitReady("c_t01", 7);
        pushT10();
        applyStimulus(1'b0, 1'b1);
        waitReady("c_t10", 7);
        pushT11();
        applyStimulus(1'b0, 1'b1);
        waitReady("c_t11", 7);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fdC_pulse", 64'(frame_done), 64'd1);
        checkOutput("fdC_busy", 64'(busy), 64'd0);
        checkOutput("fdC_ready", 64'(pixel_ready), 64'd0);
        @(negedge clk);
        checkOutput("fdC_single", 64'(frame_done), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("fd_total", 64'(fd_count), 64'd2);
        checkOutput("reads_left", 64'(exp_addrs.size()), 64'd0);
        checkOutput("tiles_left", 64'(exp_tiles.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_row_feeder.md
# conv_row_feeder

Producer side of the convolution pixel-row handshake: walks a row-major image in external pixel memory tile by tile. For each tile it fetches the `Pix` core pixels plus `kx/2` halo pixels on each side, and presents them as `pixel_row` / `west_paddings` with `pixel_ready`. The conv loop consumes the tile and acknowledges with `kernel_loop_done`; the feeder then advances to the next tile.

## Interface
Parameters:
- `kx`, 3: kernel width; halo `H = kx/2`.
- `Pix`, 3: core pixels per tile.
- `RES`, 8: pixel width in bits.
- `IMG_W`, 12: image width; must be a multiple of `Pix`.
- `IMG_H`, 4: image height in rows.
- `ADDR_W`, `$clog2(IMG_W*IMG_H)`: pixel memory address width.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  frame start; accepted only in IDLE.
- `mem_rd_en`  out  1  pixel memory read strobe.
- `mem_addr`  out  ADDR_W  read address, `row*IMG_W + col`.
- `mem_rd_data`  in  RES  read data; valid exactly 1 cycle after `mem_rd_en`.
- `pixel_row`  out  RES x (Pix+H)  columns `t*Pix .. t*Pix+Pix+H-1`.
- `west_paddings`  out  RES x H  columns `t*Pix-H .. t*Pix-1`.
- `pixel_ready`  out  1  tile valid; held until acknowledged.
- `kernel_loop_done`  in  1  tile acknowledge from the conv loop.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the final tile is acknowledged.

## Operation
- Slots per tile: `N = Pix + 2H`. Slot k maps to column `c = t*Pix - H + k`.
- States and transitions:
  - IDLE → FETCH on `start`. Tile counter `t = 0`, row counter `r = 0`.
  - FETCH lasts N cycles, one slot per cycle, in increasing k.
  - In-range slot (`0 <= c < IMG_W`): `mem_rd_en=1`, `mem_addr = r*IMG_W + c`. The data is captured into the slot register the next cycle.
  - Out-of-range slot: handling depends on the macro (see Configuration).
  - DRAIN: one cycle to capture the last read.
  - PRESENT: `pixel_ready=1`. `pixel_row` and `west_paddings` are held stable.
  - On `kernel_loop_done=1` in PRESENT, advance the tile:
    - `t+1` while `t < IMG_W/Pix - 1`;
    - otherwise `t=0` and `r+1`;
    - after the last tile of the last row, go to IDLE and pulse `frame_done`.
- Ignored inputs:
  - `kernel_loop_done` outside PRESENT.
  - `start` outside IDLE.
- Address arithmetic runs at ADDR_W bits. Column arithmetic is signed so negative columns are detected.

## Timing
- Reset (rst_n low at a clock edge) forces all of the following, even mid-frame with an outstanding read:
  - state IDLE, counters 0;
  - `pixel_row` and `west_paddings` all zero;
  - `pixel_ready=0`, `busy=0`, `frame_done=0`, `mem_rd_en=0`, `mem_addr=0`.
  - The in-flight `mem_rd_data` is discarded.
- `start` sampled in cycle 0: FETCH occupies cycles 1..N, DRAIN is cycle N+1, and `pixel_ready` is first high in cycle N+2.
- `kernel_loop_done` sampled in cycle a: `pixel_ready` is low in cycle a+1, and the next tile's `pixel_ready` rises in cycle a+N+2.
- `frame_done` is high in the cycle after the final acknowledge, coincident with returning to IDLE.
- `kernel_loop_done` may be asserted in the same cycle `pixel_ready` first rises; that counts as an immediate acknowledge.
- Exactly one `mem_rd_en` per in-range slot; never two reads in one cycle.

## Configuration
- `CONV_FEEDER_REPLICATE_EN` undefined: out-of-range slots issue no read and load 0 (zero padding).
- `CONV_FEEDER_REPLICATE_EN` defined: out-of-range slots issue a read at the clamped column (0 or IMG_W-1), replicating the edge pixel. Every tile then performs exactly N reads.

## Test plan
All scenarios use `kx=3`, `Pix=3`, `IMG_W=6`, `IMG_H=2`, and memory `img[r][c] = 10r + c + 1`.
- Zero padding, row 0 tile 0:
  - Stimulus: `start`.
  - Response: reads at addresses 0,1,2,3 only; `west_paddings=[0]`, `pixel_row=[1,2,3,4]`; `pixel_ready` rises in cycle 7.
- Zero padding, row 0 tile 1 after acknowledge:
  - Response: `west_paddings=[3]`, `pixel_row=[4,5,6,0]`; reads at addresses 2,3,4,5.
- Row wrap:
  - Stimulus: acknowledge the second tile.
  - Response: row 1 tile 0 has `west_paddings=[0]`, `pixel_row=[11,12,13,14]`, read from addresses 6..9.
- Full frame:
  - Stimulus: acknowledge all 4 tiles.
  - Response: single `frame_done` pulse; `busy=0`; a `start` during the frame is ignored.
- With `CONV_FEEDER_REPLICATE_EN`:
  - Response: tile 0 `west_paddings=[1]`; tile 1 `pixel_row=[4,5,6,6]`; 5 reads per tile.
- Reset mid-FETCH of tile 1:
  - Response: all outputs zero next cycle, state IDLE; a new `start` restarts at tile 0 with identical data.
